// File: rtl/tdm_synth_pkg.sv
// tdm_synth_pkg: shared constants, wave-select codes and FSM encoding for the TDM voice scheduler
//   D_W, VOICES, VOICES_BITS, PHASE_W, PIPE_LAT : datapath defaults
//   ACC_W    : mix accumulator width, sized so VOICES full-scale samples cannot overflow
//   WAVE_*   : wave-select codes carried on bram_wave
//   state_e  : scheduler FSM states
package tdm_synth_pkg;
    localparam int D_W         = 16;
    localparam int VOICES      = 4;
    localparam int VOICES_BITS = 2;
    localparam int PHASE_W     = 24;
    localparam int PIPE_LAT    = 2;
    localparam int ACC_W       = D_W + VOICES_BITS;

    localparam logic [1:0] WAVE_SIN = 2'd0;
    localparam logic [1:0] WAVE_TRI = 2'd1;
    localparam logic [1:0] WAVE_SQR = 2'd2;
    localparam logic [1:0] WAVE_SAW = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_OUTPUT
    } state_e;
endpackage

// File: rtl/nco_bank.sv
// nco_bank: per-voice register file (fcw, wave, enable, optional gain) and phase accumulators
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   cfg_*_i             : config write port, lands on the next edge
//   issue_i, slot_i     : advance the phase of voice slot_i this cycle
//   addr_o/wave_o/en_o  : lookup fields of voice slot_i (pre-update values)
//   gain_tag_i, gain_o  : gain of the voice whose sample is returning (VOICE_GAIN_EN only)
// Optional feature macro: VOICE_GAIN_EN
module nco_bank
    import tdm_synth_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_we_i,
    input  logic [VOICES_BITS-1:0] cfg_voice_i,
    input  logic [PHASE_W-1:0]     cfg_fcw_i,
    input  logic [1:0]             cfg_wave_i,
    input  logic                   cfg_en_i,
`ifdef VOICE_GAIN_EN
    input  logic [1:0]             cfg_gain_i,
    input  logic [VOICES_BITS-1:0] gain_tag_i,
    output logic [1:0]             gain_o,
`endif
    input  logic                   issue_i,
    input  logic [VOICES_BITS-1:0] slot_i,
    output logic [7:0]             addr_o,
    output logic [1:0]             wave_o,
    output logic                   en_o
);
    logic [PHASE_W-1:0] phase_q [VOICES];
    logic [PHASE_W-1:0] fcw_q   [VOICES];
    logic [1:0]         wave_q  [VOICES];
    logic [VOICES-1:0]  en_q;

    // A disabled voice restarts from phase 0 when it is next issued
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < VOICES; i++) begin
                phase_q[i] <= '0;
                fcw_q[i]   <= '0;
                wave_q[i]  <= '0;
            end
            en_q <= '0;
        end else begin
            if (cfg_we_i) begin
                fcw_q[cfg_voice_i]  <= cfg_fcw_i;
                wave_q[cfg_voice_i] <= cfg_wave_i;
                en_q[cfg_voice_i]   <= cfg_en_i;
            end
            if (issue_i)
                phase_q[slot_i] <= en_q[slot_i] ? phase_q[slot_i] + fcw_q[slot_i] : '0;
        end
    end

    assign addr_o = phase_q[slot_i][PHASE_W-1 -: 8];
    assign wave_o = wave_q[slot_i];
    assign en_o   = en_q[slot_i];

`ifdef VOICE_GAIN_EN
    logic [1:0] gain_q [VOICES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < VOICES; i++) gain_q[i] <= '0;
        end else if (cfg_we_i) begin
            gain_q[cfg_voice_i] <= cfg_gain_i;
        end
    end

    assign gain_o = gain_q[gain_tag_i];
`endif
endmodule

// File: rtl/tdm_voice_scheduler.sv
// tdm_voice_scheduler: time-multiplexes one wavetable BRAM across VOICES NCO voices and mixes the results
//   sys_clk, sys_rst          : clock, asynchronous active-high reset
//   sample_tick               : starts a frame; ticks during a frame are dropped and flag overrun
//   cfg_we/voice/fcw/wave/en  : voice configuration write
//   cfg_gain                  : per-voice attenuation shift (VOICE_GAIN_EN only)
//   bram_addr/wave/chan/en    : lookup issued to the BRAM interface, one voice per ISSUE cycle
//   smp_in, smp_vld           : returned sample, PIPE_LAT cycles after its lookup
//   mix_out, mix_vld          : average of the frame's returned samples, 1-cycle strobe
//   busy, overrun             : frame in progress, sticky dropped-tick flag
// Optional feature macro: VOICE_GAIN_EN
module tdm_voice_scheduler
    import tdm_synth_pkg::*;
(
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   sample_tick,
    input  logic                   cfg_we,
    input  logic [VOICES_BITS-1:0] cfg_voice,
    input  logic [PHASE_W-1:0]     cfg_fcw,
    input  logic [1:0]             cfg_wave,
    input  logic                   cfg_en,
    input  logic [1:0]             cfg_gain,
    output logic [7:0]             bram_addr,
    output logic [1:0]             bram_wave,
    output logic [VOICES_BITS-1:0] bram_chan,
    output logic                   bram_en,
    input  logic [D_W-1:0]         smp_in,
    input  logic                   smp_vld,
    output logic [D_W-1:0]         mix_out,
    output logic                   mix_vld,
    output logic                   busy,
    output logic                   overrun
);
    localparam int DCNT_W = $clog2(PIPE_LAT + 1);

    state_e                 state_q, state_d;
    logic [VOICES_BITS-1:0] slot_q, slot_d;
    logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [PIPE_LAT-1:0]    vld_q;
    logic [7:0]             addr_q;
    logic [1:0]             wave_q;
    logic [VOICES_BITS-1:0] chan_q;
    logic [D_W-1:0]         mix_q;
    logic                   mix_vld_q, overrun_q;
    logic                   issue, out_en;
    logic [7:0]             nco_addr;
    logic [1:0]             nco_wave;
    logic                   nco_en;
    logic [D_W-1:0]         smp_val;

`ifdef VOICE_GAIN_EN
    logic [VOICES_BITS-1:0] tag_q [PIPE_LAT];
    logic [1:0]             gain;

    // Voice tag travels alongside the lookup so the returning sample picks up its own gain
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= bram_chan;
            for (int i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign smp_val = smp_in >> gain;
`else
    logic unused_gain;
    assign unused_gain = ^cfg_gain;
    assign smp_val     = smp_in;
`endif

    nco_bank u_nco (
        .clk_i       (sys_clk),
        .rst_i       (sys_rst),
        .cfg_we_i    (cfg_we),
        .cfg_voice_i (cfg_voice),
        .cfg_fcw_i   (cfg_fcw),
        .cfg_wave_i  (cfg_wave),
        .cfg_en_i    (cfg_en),
`ifdef VOICE_GAIN_EN
        .cfg_gain_i  (cfg_gain),
        .gain_tag_i  (tag_q[PIPE_LAT-1]),
        .gain_o      (gain),
`endif
        .issue_i     (issue),
        .slot_i      (slot_q),
        .addr_o      (nco_addr),
        .wave_o      (nco_wave),
        .en_o        (nco_en)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == ST_IDLE)  ? (sample_tick ? ST_ISSUE : ST_IDLE) :
                  (state_q == ST_ISSUE) ? ((slot_q == VOICES_BITS'(VOICES - 1)) ? ST_DRAIN : ST_ISSUE) :
                  (state_q == ST_DRAIN) ? ((dcnt_q == DCNT_W'(PIPE_LAT - 1)) ? ST_OUTPUT : ST_DRAIN) :
                  ST_IDLE;
    end

    // Lookup fields are live only while issuing; otherwise the last issued values are held
    always_comb begin
        issue     = state_q == ST_ISSUE;
        out_en    = state_q == ST_OUTPUT;
        busy      = state_q != ST_IDLE;
        bram_en   = issue & nco_en;
        bram_addr = issue ? nco_addr : addr_q;
        bram_wave = issue ? nco_wave : wave_q;
        bram_chan = issue ? slot_q : chan_q;
    end

    // Returned samples count only when their slot was issued enabled; IDLE discards stragglers
    always_comb begin
        slot_d = issue ? slot_q + VOICES_BITS'(1) : '0;
        dcnt_d = (state_q == ST_DRAIN) ? dcnt_q + DCNT_W'(1) : '0;
        acc_d  = (state_q == ST_IDLE) ? '0 :
                 acc_q + ((smp_vld && vld_q[PIPE_LAT-1]) ? ACC_W'(smp_val) : '0);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            slot_q    <= '0;
            dcnt_q    <= '0;
            acc_q     <= '0;
            vld_q     <= '0;
            addr_q    <= '0;
            wave_q    <= '0;
            chan_q    <= '0;
            mix_q     <= '0;
            mix_vld_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            dcnt_q    <= dcnt_d;
            acc_q     <= acc_d;
            vld_q     <= (vld_q << 1) | PIPE_LAT'(bram_en);
            addr_q    <= bram_addr;
            wave_q    <= bram_wave;
            chan_q    <= bram_chan;
            mix_q     <= out_en ? acc_q[ACC_W-1:VOICES_BITS] : mix_q;
            mix_vld_q <= out_en;
            overrun_q <= overrun_q | (sample_tick & busy);
        end
    end

    assign mix_out = mix_q;
    assign mix_vld = mix_vld_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_tdm_voice_scheduler.sv
// tb_tdm_voice_scheduler: table-driven frames with a BRAM latency model and a mix scoreboard
module tb_tdm_voice_scheduler;
    import tdm_synth_pkg::*;

    logic        sys_clk = 1'b0, sys_rst = 1'b1, sample_tick = 1'b0, cfg_we = 1'b0, cfg_en = 1'b0;
    logic [1:0]  cfg_voice = '0, cfg_wave = '0, cfg_gain = '0;
    logic [23:0] cfg_fcw = '0;
    logic [7:0]  bram_addr;
    logic [1:0]  bram_wave, bram_chan;
    logic        bram_en, smp_vld, mix_vld, busy, overrun;
    logic [15:0] smp_in, mix_out;

    tdm_voice_scheduler dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_fcw(cfg_fcw), .cfg_wave(cfg_wave),
        .cfg_en(cfg_en), .cfg_gain(cfg_gain),
        .bram_addr(bram_addr), .bram_wave(bram_wave), .bram_chan(bram_chan), .bram_en(bram_en),
        .smp_in(smp_in), .smp_vld(smp_vld),
        .mix_out(mix_out), .mix_vld(mix_vld), .busy(busy), .overrun(overrun)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // BRAM model: returns the per-voice sample value two cycles after an enabled lookup
    logic [15:0] smp_val [4];
    logic [1:0]  p_vld = '0;
    logic [1:0]  p_chan [2];
    always @(posedge sys_clk) begin
        p_vld     <= {p_vld[0], bram_en};
        p_chan[0] <= bram_chan;
        p_chan[1] <= p_chan[0];
    end
    assign smp_vld = p_vld[1];
    assign smp_in  = smp_val[p_chan[1]];

    int total = 0, bad = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] mix;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    always @(negedge sys_clk) begin
        if (mix_vld) begin
            if (sb.size() == 0) check("spurious mix_vld", 32'(mix_vld), 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("mix_out", 32'(mix_out), 32'(e.mix));
                check("mix latency", 32'(cyc - e.cyc), 8);
            end
        end
    end

    logic [7:0] ia [4];
    logic [3:0] ie;
    logic [7:0] iw, ic;
    logic       busy1, busy8;

    task automatic run_frame(input logic [15:0] mix);
        @(negedge sys_clk);
        sample_tick = 1'b1;
        sb.push_back(exp_t'{mix, cyc});
        @(negedge sys_clk);
        sample_tick = 1'b0;
        busy1 = busy;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) @(negedge sys_clk);
            ia[s]        = bram_addr;
            ie[s]        = bram_en;
            iw[2*s +: 2] = bram_wave;
            ic[2*s +: 2] = bram_chan;
        end
        repeat (4) @(negedge sys_clk);
        busy8 = busy;
        @(negedge sys_clk);
        check("busy in frame", 32'(busy1), 1);
        check("busy after output", 32'(busy8), 0);
        check("chan order", 32'(ic), 32'hE4);
        check("frame retired", 32'(sb.size()), 0);
    endtask

    task automatic cfg(input logic [1:0] v, input logic [23:0] f, input logic [1:0] w,
                       input logic e, input logic [1:0] g);
        @(negedge sys_clk);
        cfg_we = 1'b1; cfg_voice = v; cfg_fcw = f; cfg_wave = w; cfg_en = e; cfg_gain = g;
        @(negedge sys_clk);
        cfg_we = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  en;
        logic [63:0] smp;
        logic [15:0] mix;
    } vec_t;
    vec_t tbl [6];

    logic [7:0]  wexp [3];
    logic [15:0] gain_exp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b1111, {4{16'h8000}}, 16'h8000};
        tbl[1] = '{4'b0001, {16'h0, 16'h0, 16'h0, 16'h8000}, 16'h2000};
        tbl[2] = '{4'b0000, {4{16'hFFFF}}, 16'h0000};
        tbl[3] = '{4'b1111, {4{16'hFFFF}}, 16'hFFFF};
        tbl[4] = '{4'b1010, {16'h4321, 16'h0, 16'h1234, 16'h0}, 16'h1555};
        tbl[5] = '{4'b0110, {16'hFFFF, 16'h0002, 16'h0003, 16'hFFFF}, 16'h0001};
        wexp   = '{8'h00, 8'hFF, 8'hFF};
`ifdef VOICE_GAIN_EN
        gain_exp = 16'h1000;
`else
        gain_exp = 16'h2000;
`endif
        for (int v = 0; v < 4; v++) smp_val[v] = 16'h0100;

        repeat (3) @(negedge sys_clk);
        check("rst mix_out", 32'(mix_out), 0);
        check("rst mix_vld", 32'(mix_vld), 0);
        check("rst busy", 32'(busy), 0);
        check("rst overrun", 32'(overrun), 0);
        check("rst bram_en", 32'(bram_en), 0);
        check("rst bram_addr", 32'(bram_addr), 0);
        sys_rst = 1'b0;

        cfg(2'd0, 24'h010000, WAVE_SIN, 1'b1, 2'd0);
        for (int k = 0; k < 4; k++) begin
            run_frame(16'h0040);
            check("v0 addr", 32'(ia[0]), 32'(k));
            check("v0 only en", 32'(ie), 32'b0001);
        end
        cfg(2'd0, 24'h010000, WAVE_SIN, 1'b0, 2'd0);
        run_frame(16'h0000);
        check("v0 disabled en", 32'(ie), 0);
        cfg(2'd0, 24'h010000, WAVE_SIN, 1'b1, 2'd0);
        run_frame(16'h0040);
        check("v0 phase zeroed", 32'(ia[0]), 0);

        cfg(2'd0, 24'h0, WAVE_SIN, 1'b0, 2'd0);
        cfg(2'd1, 24'hFFFFFF, WAVE_SAW, 1'b1, 2'd0);
        for (int k = 0; k < 3; k++) begin
            run_frame(16'h0040);
            check("v1 wrap addr", 32'(ia[1]), 32'(wexp[k]));
            check("v1 wave", 32'(iw[3:2]), 32'(WAVE_SAW));
            check("v1 only en", 32'(ie), 32'b0010);
        end

        for (int i = 0; i < 6; i++) begin
            for (int v = 0; v < 4; v++) begin
                cfg(2'(v), 24'h000100, 2'(v), tbl[i].en[v], 2'd0);
                smp_val[v] = tbl[i].smp[16*v +: 16];
            end
            run_frame(tbl[i].mix);
            check("tbl en", 32'(ie), 32'(tbl[i].en));
            check("tbl wave", 32'(iw), 32'hE4);
        end

        for (int v = 0; v < 4; v++) begin
            cfg(2'(v), 24'h0, WAVE_SIN, 1'b1, 2'd0);
            smp_val[v] = 16'h8000;
        end
        check("overrun idle", 32'(overrun), 0);
        @(negedge sys_clk);
        sample_tick = 1'b1;
        sb.push_back(exp_t'{16'h8000, cyc});
        @(negedge sys_clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge sys_clk);
        sample_tick = 1'b1;
        @(negedge sys_clk);
        sample_tick = 1'b0;
        repeat (6) @(negedge sys_clk);
        check("overrun set", 32'(overrun), 1);
        check("overrun one mix", 32'(sb.size()), 0);
        repeat (6) @(negedge sys_clk);
        run_frame(16'h8000);
        check("overrun sticky", 32'(overrun), 1);

        @(negedge sys_clk);
        sample_tick = 1'b1;
        sb.push_back(exp_t'{16'h8000, cyc});
        @(negedge sys_clk);
        sample_tick = 1'b0;
        repeat (4) @(negedge sys_clk);
        sys_rst = 1'b1;
        sb.delete();
        @(negedge sys_clk);
        check("midrst mix_out", 32'(mix_out), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst overrun", 32'(overrun), 0);
        check("midrst bram_chan", 32'(bram_chan), 0);
        check("midrst bram_en", 32'(bram_en), 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (12) @(negedge sys_clk);
        run_frame(16'h0000);
        check("post rst en", 32'(ie), 0);
        for (int v = 0; v < 4; v++) cfg(2'(v), 24'h0, WAVE_SIN, 1'b1, 2'd0);
        run_frame(16'h8000);
        check("post rst en all", 32'(ie), 32'b1111);

        for (int v = 1; v < 4; v++) cfg(2'(v), 24'h0, WAVE_SIN, 1'b0, 2'd0);
        cfg(2'd0, 24'h0, WAVE_SIN, 1'b1, 2'd1);
        run_frame(gain_exp);

        check("scoreboard empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
